// File: rtl/msrv32_pkg.sv
// msrv32_pkg: shared types and alignment helper for the fetch-address generator
package msrv32_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_MRET, SRC_TRAP} src_e;
    function automatic logic [1:0] low_mask(input bit c_ext);
        return c_ext ? 2'b10 : 2'b00;
    endfunction
endpackage

// File: rtl/msrv32_pc_gen_if.sv
// msrv32_pc_gen_if: instruction-fetch address bus between pc generator and AHB master
interface msrv32_pc_gen_if #(parameter int XLEN = 32);
    logic            ahb_ready;
    logic [XLEN-1:0] i_addr;
    logic            i_valid;
    modport master (input ahb_ready, output i_addr, i_valid);
    modport slave (output ahb_ready, input i_addr, i_valid);
endinterface

// File: rtl/msrv32_redirect_arb.sv
// msrv32_redirect_arb: priority select, alignment and misalignment detection of redirects
module msrv32_redirect_arb
    import msrv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int C_EXT = 0
) (
    input  logic            branch_taken,
    input  logic [XLEN-2:0] iaddr,
    input  logic            trap_taken,
    input  logic [XLEN-1:0] trap_address,
    input  logic            mret,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] target,
    output src_e            src,
    output logic            misaligned
);
    logic [XLEN-1:0] br, sel;
    assign br = {iaddr, 1'b0};
    assign sel = trap_taken ? trap_address : epc;
    assign misaligned = branch_taken & ~trap_taken & ~mret & (C_EXT == 0) & br[1];
    assign src = trap_taken ? SRC_TRAP : mret ? SRC_MRET :
                 (branch_taken & ~misaligned) ? SRC_BRANCH : SRC_NONE;
    assign target = (trap_taken | mret) ? {sel[XLEN-1:2], sel[1:0] & low_mask(C_EXT != 0)} : br;
endmodule

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen: registered fetch PC / issue PC generator with buffered redirects
module msrv32_pc_gen
    import msrv32_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] BOOT_ADDRESS = '0,
    parameter int              C_EXT        = 0
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    msrv32_pc_gen_if.master        bus,
    input  logic                   stall_in,
    input  logic                   branch_taken_in,
    input  logic [XLEN-2:0]        iaddr_in,
    input  logic                   trap_taken_in,
    input  logic [XLEN-1:0]        trap_address_in,
    input  logic                   mret_in,
    input  logic [XLEN-1:0]        epc_in,
    output logic [XLEN-1:0]        pc_out,
    output logic [XLEN-1:0]        pc_plus_4_out,
    output logic                   misaligned_instr_out,
    output logic                   redirect_pending_out
);
    localparam logic [XLEN-1:0] INC = XLEN'(C_EXT != 0 ? 2 : 4);
    state_e          state, state_nxt;
    src_e            src, pend_src;
    logic [XLEN-1:0] target, pend_target;
    logic            mis, adv, ev;
    msrv32_redirect_arb #(.XLEN(XLEN), .C_EXT(C_EXT)) u_arb (
        .branch_taken (branch_taken_in),
        .iaddr        (iaddr_in),
        .trap_taken   (trap_taken_in),
        .trap_address (trap_address_in),
        .mret         (mret_in),
        .epc          (epc_in),
        .target       (target),
        .src          (src),
        .misaligned   (mis)
    );
    assign adv = bus.ahb_ready & ~stall_in & (state != BOOT);
    assign ev = src != SRC_NONE;
    assign pc_plus_4_out = pc_out + XLEN'(4);
    assign redirect_pending_out = pend_src != SRC_NONE;
    always_comb begin
        state_nxt = state;
        state_nxt = adv ? RUN : (ev || state == HOLD) ? HOLD : RUN;
    end
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) state <= BOOT;
        else state <= state_nxt;
    end
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            bus.i_addr <= BOOT_ADDRESS;
            bus.i_valid <= 1'b0;
            pc_out <= BOOT_ADDRESS;
            misaligned_instr_out <= 1'b0;
            pend_src <= SRC_NONE;
            pend_target <= '0;
        end else begin
            bus.i_valid <= 1'b1;
            misaligned_instr_out <= mis;
            if (adv) begin
                pc_out <= bus.i_addr;
                bus.i_addr <= ev ? target : redirect_pending_out ? pend_target : bus.i_addr + INC;
                pend_src <= SRC_NONE;
            end else if (ev && src >= pend_src) begin
                pend_src <= src;
                pend_target <= target;
            end
        end
    end
endmodule

// File: tb/tb_msrv32_pc_gen.sv
// tb_msrv32_pc_gen: directed self-checking bench for msrv32_pc_gen (C_EXT=0 and C_EXT=1)
module tb_msrv32_pc_gen;
    logic        clk = 0, rst = 1, ready = 0, stall = 0;
    logic        br = 0, trap = 0, mret = 0;
    logic [30:0] iaddr = '0;
    logic [31:0] trap_addr = '0, epc = '0;
    logic [31:0] pc0, pc40, pc1, pc41;
    logic        mis0, pend0, mis1, pend1;
    int          n_checks = 0, n_fail = 0;
    msrv32_pc_gen_if #(.XLEN(32)) if0 ();
    msrv32_pc_gen_if #(.XLEN(32)) if1 ();
    assign if0.ahb_ready = ready;
    assign if1.ahb_ready = ready;
    always #5 clk = ~clk;
    msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(0)) dut0 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(if0), .stall_in(stall),
        .branch_taken_in(br), .iaddr_in(iaddr), .trap_taken_in(trap), .trap_address_in(trap_addr),
        .mret_in(mret), .epc_in(epc), .pc_out(pc0), .pc_plus_4_out(pc40),
        .misaligned_instr_out(mis0), .redirect_pending_out(pend0));
    msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(1)) dut1 (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst), .bus(if1), .stall_in(stall),
        .branch_taken_in(br), .iaddr_in(iaddr), .trap_taken_in(trap), .trap_address_in(trap_addr),
        .mret_in(mret), .epc_in(epc), .pc_out(pc1), .pc_plus_4_out(pc41),
        .misaligned_instr_out(mis1), .redirect_pending_out(pend1));
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    initial begin
        step();
        step();
        check("rst_iaddr", if0.i_addr, 32'h0);
        check("rst_pc", pc0, 32'h0);
        check("rst_valid", 32'(if0.i_valid), 32'h0);
        check("rst_pend", 32'(pend0), 32'h0);
        check("rst_mis", 32'(mis0), 32'h0);
        rst = 0;
        ready = 1;
        step();
        check("boot_valid", 32'(if0.i_valid), 32'h1);
        check("boot_iaddr", if0.i_addr, 32'h0);
        step();
        check("seq_iaddr4", if0.i_addr, 32'h4);
        check("seq_pc0", pc0, 32'h0);
        step();
        check("seq_iaddr8", if0.i_addr, 32'h8);
        check("seq_pc4", pc0, 32'h4);
        step();
        check("seq_iaddr12", if0.i_addr, 32'hC);
        check("seq_pc8", pc0, 32'h8);
        check("pc_plus_4", pc40, 32'hC);
        check("c1_seq", if1.i_addr, 32'h6);
        br = 1;
        iaddr = 31'h80;
        step();
        br = 0;
        check("br_iaddr", if0.i_addr, 32'h100);
        check("br_pc", pc0, 32'hC);
        step();
        check("br_next", if0.i_addr, 32'h104);
        check("br_nomis", 32'(mis0), 32'h0);
        check("c1_br_next", if1.i_addr, 32'h102);
        br = 1;
        iaddr = 31'h81;
        step();
        br = 0;
        check("mis_seq", if0.i_addr, 32'h108);
        check("mis_pulse", 32'(mis0), 32'h1);
        check("c1_br102", if1.i_addr, 32'h102);
        check("c1_nomis", 32'(mis1), 32'h0);
        step();
        check("mis_end", 32'(mis0), 32'h0);
        check("mis_seq2", if0.i_addr, 32'h10C);
        check("c1_br104", if1.i_addr, 32'h104);
        ready = 0;
        br = 1;
        iaddr = 31'h100;
        step();
        br = 0;
        check("hold_iaddr", if0.i_addr, 32'h10C);
        check("hold_pend", 32'(pend0), 32'h1);
        check("hold_valid", 32'(if0.i_valid), 32'h1);
        trap = 1;
        trap_addr = 32'h80;
        step();
        trap = 0;
        mret = 1;
        epc = 32'h300;
        step();
        mret = 0;
        check("hold_iaddr2", if0.i_addr, 32'h10C);
        ready = 1;
        step();
        check("pend_apply", if0.i_addr, 32'h80);
        check("pend_pc", pc0, 32'h10C);
        check("pend_clear", 32'(pend0), 32'h0);
        trap = 1;
        mret = 1;
        trap_addr = 32'h83;
        epc = 32'h40;
        step();
        trap = 0;
        mret = 0;
        check("trap_mret", if0.i_addr, 32'h80);
        check("c1_trap_align", if1.i_addr, 32'h82);
        step();
        check("trap_next", if0.i_addr, 32'h84);
        trap = 1;
        trap_addr = 32'hFFFF_FFFC;
        step();
        trap = 0;
        check("wrap_pre", if0.i_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_iaddr", if0.i_addr, 32'h0);
        check("wrap_pc", pc0, 32'hFFFF_FFFC);
        check("wrap_pc4", pc40, 32'h0);
        stall = 1;
        br = 1;
        iaddr = 31'h20;
        step();
        br = 0;
        check("stall_pc", pc0, 32'hFFFF_FFFC);
        check("stall_iaddr", if0.i_addr, 32'h0);
        check("stall_pend", 32'(pend0), 32'h1);
        rst = 1;
        step();
        check("rst2_iaddr", if0.i_addr, 32'h0);
        check("rst2_pend", 32'(pend0), 32'h0);
        check("rst2_valid", 32'(if0.i_valid), 32'h0);
        check("rst2_pc", pc0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
